// File: rtl/ddr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_sched_pkg
// Brief    : State encoding, command indices and counter widths for the
//            single-bank DDR command scheduler.
// Revision : 1.0
// ============================================================================
package ddr_sched_pkg;

    localparam int TCNT_W  = 9;
    localparam int REFI_W  = 16;

    localparam int CMD_W   = 5;
    localparam int CMD_ACT = 0;
    localparam int CMD_RD  = 1;
    localparam int CMD_WR  = 2;
    localparam int CMD_PR  = 3;
    localparam int CMD_REF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACT_WAIT = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_CAS_WAIT = 3'd3,
        ST_PRE_WAIT = 3'd4,
        ST_REF_WAIT = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ddr_bank_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; combinational grant, registered
//            pointer that moves past whichever requester was granted.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= ~upd_idx_i;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_q]) begin
            gnt_o[ptr_q] = 1'b1;
        end else if (req_i[~ptr_q]) begin
            gnt_o[~ptr_q] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr_bank_scheduler
// Brief    : Single-bank open-page DDR command scheduler with two requesters,
//            tRCD/tCL/tRP/tRFC timing and periodic refresh insertion.
// Revision : 1.0
// ============================================================================
module ddr_bank_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int T_CL   = 17,
    parameter int T_RCD  = 17,
    parameter int T_RP   = 17,
    parameter int T_RFC  = 347,
    parameter int T_REFI = 7800,
    parameter int ROW_W  = 16,
    parameter int COL_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_we,
    input  logic [2*ROW_W-1:0] req_row,
    input  logic [2*COL_W-1:0] req_col,
    output logic [1:0]         gnt,
    output logic               ACT,
    output logic               RD,
    output logic               WR,
    output logic               PR,
    output logic               REF,
    output logic [ROW_W-1:0]   cmd_row,
    output logic [COL_W-1:0]   cmd_col,
    output logic               row_open,
    output logic               busy
);

    state_e             state_q, state_d, state_eff;
    logic [TCNT_W-1:0]  cnt_q, cnt_d;
    logic [REFI_W-1:0]  refi_q, refi_d;
    logic               ref_pend_q, ref_pend_d;
    logic               lock_vld_q, lock_vld_d;
    logic               lock_idx_q, lock_idx_d;
    logic [ROW_W-1:0]   open_row_q, open_row_d;
    logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]   cmd_col_q, cmd_col_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               row_open_q, row_open_d;

    logic [1:0]         w_arb_gnt;
    logic               w_use_lock, w_sel_vld, w_sel_idx, w_sel_we, w_refi_exp;
    logic [ROW_W-1:0]   w_sel_row;
    logic [COL_W-1:0]   w_sel_col;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .upd_i     (|gnt_d),
        .upd_idx_i (w_sel_idx),
        .gnt_o     (w_arb_gnt)
    );

    // A still-requesting locked winner outranks the round-robin choice.
    assign w_use_lock = lock_vld_q & req[lock_idx_q];
    assign w_sel_vld  = w_use_lock | (|w_arb_gnt);
    assign w_sel_idx  = w_use_lock ? lock_idx_q : w_arb_gnt[1];
    assign w_sel_row  = w_sel_idx ? req_row[2*ROW_W-1:ROW_W] : req_row[ROW_W-1:0];
    assign w_sel_col  = w_sel_idx ? req_col[2*COL_W-1:COL_W] : req_col[COL_W-1:0];
    assign w_sel_we   = req_we[w_sel_idx];

    assign w_refi_exp = (refi_q == '0);
    assign refi_d     = w_refi_exp ? REFI_W'(T_REFI - 1) : refi_q - REFI_W'(1);
    assign ref_pend_d = (ref_pend_q & ~cmd_d[CMD_REF]) | w_refi_exp;
    assign row_open_d = cmd_q[CMD_ACT] ? 1'b1 : (cmd_q[CMD_PR] ? 1'b0 : row_open_q);

    // A wait state whose counter has expired decides as its successor state,
    // so the next command lands exactly T cycles after the previous one.
    always_comb begin
        state_eff = state_q;
        case (state_q)
            ST_ACT_WAIT, ST_CAS_WAIT: if (cnt_q == '0) state_eff = ST_ACTIVE;
            ST_PRE_WAIT, ST_REF_WAIT: if (cnt_q == '0) state_eff = ST_IDLE;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_eff;
        cnt_d      = (cnt_q != '0) ? cnt_q - TCNT_W'(1) : '0;
        cmd_d      = '0;
        gnt_d      = '0;
        cmd_row_d  = cmd_row_q;
        cmd_col_d  = cmd_col_q;
        open_row_d = open_row_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        case (state_eff)
            ST_IDLE: begin
                if (ref_pend_q) begin
                    cmd_d[CMD_REF] = 1'b1;
                    cnt_d          = TCNT_W'(T_RFC - 1);
                    state_d        = ST_REF_WAIT;
                end else if (w_sel_vld) begin
                    cmd_d[CMD_ACT] = 1'b1;
                    cmd_row_d      = w_sel_row;
                    open_row_d     = w_sel_row;
                    lock_vld_d     = 1'b1;
                    lock_idx_d     = w_sel_idx;
                    cnt_d          = TCNT_W'(T_RCD - 1);
                    state_d        = ST_ACT_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (ref_pend_q) begin
                    cmd_d[CMD_PR] = 1'b1;
                    cnt_d         = TCNT_W'(T_RP - 1);
                    state_d       = ST_PRE_WAIT;
                end else if (lock_vld_q && !req[lock_idx_q]) begin
                    lock_vld_d = 1'b0;
                end else if (w_sel_vld) begin
                    if (w_sel_row == open_row_q) begin
                        cmd_d[CMD_WR] = w_sel_we;
                        cmd_d[CMD_RD] = ~w_sel_we;
                        gnt_d         = w_sel_idx ? 2'b10 : 2'b01;
                        cmd_col_d     = w_sel_col;
                        lock_vld_d    = 1'b0;
                        cnt_d         = TCNT_W'(T_CL - 1);
                        state_d       = ST_CAS_WAIT;
                    end else begin
                        cmd_d[CMD_PR] = 1'b1;
                        lock_vld_d    = 1'b1;
                        lock_idx_d    = w_sel_idx;
                        cnt_d         = TCNT_W'(T_RP - 1);
                        state_d       = ST_PRE_WAIT;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            refi_q     <= REFI_W'(T_REFI - 1);
            ref_pend_q <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= 1'b0;
            open_row_q <= '0;
            cmd_row_q  <= '0;
            cmd_col_q  <= '0;
            cmd_q      <= '0;
            gnt_q      <= '0;
            row_open_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            refi_q     <= refi_d;
            ref_pend_q <= ref_pend_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            open_row_q <= open_row_d;
            cmd_row_q  <= cmd_row_d;
            cmd_col_q  <= cmd_col_d;
            cmd_q      <= cmd_d;
            gnt_q      <= gnt_d;
            row_open_q <= row_open_d;
        end
    end

    assign gnt      = gnt_q;
    assign ACT      = cmd_q[CMD_ACT];
    assign RD       = cmd_q[CMD_RD];
    assign WR       = cmd_q[CMD_WR];
    assign PR       = cmd_q[CMD_PR];
    assign REF      = cmd_q[CMD_REF];
    assign cmd_row  = cmd_row_q;
    assign cmd_col  = cmd_col_q;
    assign row_open = row_open_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_ACTIVE);

endmodule
`default_nettype wire

// File: doc/ddr_bank_scheduler.md
# ddr_bank_scheduler

Single-bank DDR command scheduler that sits in front of the per-bank timing FSM. It arbitrates between two requesters, tracks the open row (open-page policy), and issues one-cycle ACT/RD/WR/PR/REF command pulses. It enforces tRCD, tCL, tRP and tRFC with internal counters and inserts periodic refreshes every tREFI cycles.

## Interface

Parameters:
- T_CL, 17, CAS latency in cycles (≥1)
- T_RCD, 17, ACT-to-CAS delay in cycles (≥1)
- T_RP, 17, PR-to-next-command delay in cycles (≥1)
- T_RFC, 347, REF-to-next-command delay in cycles (≥1, 9-bit counter)
- T_REFI, 7800, refresh interval in cycles (16-bit counter)
- ROW_W, 16, row address width
- COL_W, 10, column address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous and active-low
- req  in  2  request valid per requester; held until gnt
- req_we  in  2  1 = write, 0 = read; stable while req
- req_row  in  2*ROW_W  row per requester; requester i at [i*ROW_W +: ROW_W]
- req_col  in  2*COL_W  column per requester, same packing
- gnt  out  2  one-hot pulse in the cycle the requester's RD/WR issues
- ACT, RD, WR, PR, REF  out  1 each  command pulses; at most one high per cycle
- cmd_row  out  ROW_W  row qualified by ACT
- cmd_col  out  COL_W  column qualified by RD/WR
- row_open  out  1  a row is currently open
- busy  out  1  high whenever state ≠ IDLE and ≠ ACTIVE

## Operation

- States: IDLE, ACT_WAIT, ACTIVE, CAS_WAIT, PRE_WAIT, REF_WAIT.
- Refresh timer: counts down from T_REFI-1; at 0 sets ref_pend and reloads. ref_pend clears when REF issues.
- IDLE: if ref_pend, issue REF and go to REF_WAIT. Else, if any req, the arbiter picks a winner and locks it, ACT issues with its row and the FSM goes to ACT_WAIT. open_row is recorded.
- ACTIVE: if ref_pend, issue PR and go to PRE_WAIT; refresh has priority over hits. Else, if a locked winner exists, use it; otherwise arbitrate. On a row hit, issue RD/WR plus gnt, unlock, and go to CAS_WAIT. On a row miss, issue PR, keep the lock, and go to PRE_WAIT.
- ACT_WAIT, CAS_WAIT and PRE_WAIT/REF_WAIT return to ACTIVE, ACTIVE and IDLE respectively when the counter reaches 0.
- Arbiter: round-robin over 2. The pointer moves past the granted requester on each gnt. It points to requester 0 after reset.
- Lock: if the locked requester deasserts req in ACTIVE, the lock drops silently and no command issues that cycle. Protocol violation; no error flag.
- PR closes the row (row_open=0 on the issue cycle +1).

## Timing

- A command issued in cycle N loads its counter with T-1. The next command is legal no earlier than cycle N+T.
- Examples: ACT at N → RD/WR earliest at N+T_RCD; PR at N → ACT/REF earliest at N+T_RP.
- Decision is registered: a request seen in IDLE at cycle N produces ACT at N+1 (outputs are flops).
- Hit latency: req asserted in ACTIVE at N → RD/WR+gnt at N+1.
- Reset values: all command pulses 0, gnt 0, cmd_row 0, cmd_col 0, row_open 0, busy 0, state IDLE, ref_pend 0, refresh timer T_REFI-1.
- Reset mid-operation clears everything immediately (async); the in-flight command is abandoned.
- The refresh timer keeps counting in all states. If a second expiry occurs while ref_pend is set, it is absorbed (no queueing).

## Structure

- Package ddr_sched_pkg: state encoding constants, command one-hot indices, counter widths (9 for timing, 16 for tREFI).
- One sub-module: rr_arb2 (2-way round-robin arbiter, combinational grant plus registered pointer).

## Test plan

Bench parameters: T_RCD=3, T_CL=2, T_RP=2, T_RFC=5, T_REFI=100.

- Cold read: req[0] read row 5 col 9 at cycle 10 → ACT row 5 at 11, RD col 9 plus gnt[0] at 14, row_open=1 from 12.
- Row hit: after the cold read, req[1] write row 5 col 3 → WR plus gnt[1] the cycle after CAS_WAIT ends (16), no ACT.
- Row miss: req[0] row 7 while row 5 is open → PR, ACT row 7 two cycles later, RD three cycles after that.
- Fairness: both req held continuously on row 5 → gnt alternates 0,1,0,1.
- Refresh preemption: ref_pend with row open and a pending hit → PR, REF 2 cycles later, busy for 5, then ACT before the hit is served.
- Async reset during ACT_WAIT → all outputs 0 immediately; state IDLE; the first request afterwards is served as a cold read.
